if_id_pipe: RTL and testbench
=============================

# if_id_pipe

Parametrised IF/ID pipeline stage with a valid/ready handshake, flush, and an optional two-entry skid buffer. It carries the fetched instruction, its address and a fetch-fault flag from the fetch stage to decode. Unlike a plain register, it honours back-pressure from decode, stalls fetch without losing data, and presents a NOP whenever it holds no valid instruction. It sits between the PC/fetch unit and the decoder in the RISC-V core.

## Interface

**Parameters**
- `DW`, 32: instruction width.
- `AW`, 32: instruction address width.
- `NOP_INST`, 32'h0000_0013: value driven on `inst_o` when the stage is empty (`addi x0,x0,0`).

**Ports**
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `flush_i`, input, 1: discard all held entries (branch/jump redirect).
- `in_valid_i`, input, 1: fetch presents a valid instruction.
- `in_ready_o`, output, 1: stage can accept. A transfer occurs when `in_valid_i && in_ready_o`.
- `inst_i`, input, DW: fetched instruction.
- `inst_addr_i`, input, AW: address of `inst_i`.
- `fault_i`, input, 1: fetch-access fault tag for this instruction.
- `out_valid_o`, output, 1: decode side holds a valid instruction.
- `out_ready_i`, input, 1: decode accepts. A transfer occurs when `out_valid_o && out_ready_i`.
- `inst_o`, output, DW: instruction to decode. Equals `NOP_INST` when `out_valid_o=0`.
- `inst_addr_o`, output, AW: address. Equals 0 when `out_valid_o=0`.
- `fault_o`, output, 1: fault tag. Equals 0 when `out_valid_o=0`.

## Operation

- **Storage.** A main entry drives the outputs. A skid entry exists only with `IF_ID_SKID_EN`.
- **Occupancy states.**
  - EMPTY: `out_valid_o=0`.
  - ONE: main entry valid.
  - TWO: main and skid valid. Exists only with skid.
- **Transitions** (in = input transfer, out = output transfer):
  - EMPTY, in → ONE. Main ← input.
  - ONE, in and out → ONE. Main ← input.
  - ONE, out only → EMPTY.
  - ONE, in only → TWO. Skid ← input. Without skid this case cannot occur.
  - TWO, out → ONE. Main ← skid. No input is accepted in TWO.
  - Any state, neither transfer → hold.
- **Flush.** Priority: `rst` > `flush_i` > handshake.
  - Next state is EMPTY.
  - An input presented in the same cycle is dropped, even if `in_ready_o=1`.
  - An output transfer in the flush cycle still counts as consumed by decode.
- **Reset.** Next state is EMPTY. Outputs show NOP/0/0. `in_ready_o=1` after the reset edge. Reset mid-operation discards all entries.
- **Ordering.** Instructions leave in acceptance order. No duplication and no loss except by flush or reset.
- **Stable outputs.** `inst_o`, `inst_addr_o` and `fault_o` are stable while `out_valid_o=1 && out_ready_i=0`.

## Timing

- **Latency.** One cycle from input transfer to `out_valid_o=1`.
- **Throughput.** One instruction per cycle when `out_ready_i` is held at 1.
- **Ready.**
  - With skid: `in_ready_o` is registered and equals (state ≠ TWO). There is no combinational path from `out_ready_i` to `in_ready_o`.
  - Without skid: `in_ready_o = !out_valid_o || out_ready_i`, which is combinational.
- **Output timing.** `out_valid_o` and the data outputs come from registers plus a mux on the valid bit. There is no path from inputs.
- **Reset values.** `out_valid_o=0`, `inst_o=NOP_INST`, `inst_addr_o=0`, `fault_o=0`, `in_ready_o=1`.

## Configuration

- **`IF_ID_SKID_EN` defined:**
  - Two-entry skid buffer; state TWO is reachable.
  - `in_ready_o` is registered, which breaks the decode-to-fetch ready timing path.
  - Full throughput is kept across a single-cycle decode stall.
- **Undefined:**
  - Single entry; states EMPTY and ONE only.
  - `in_ready_o` is combinational from `out_ready_i`.
  - Smaller area. Functional ordering and flush behaviour are identical.

## Test plan

- **Reset.** Assert `rst` for 2 cycles with `in_valid_i=1`, then release → `out_valid_o=0`, `inst_o=32'h13`, `inst_addr_o=0`, `in_ready_o=1`.
- **Streaming.** `out_ready_i=1`; push addresses 0x0, 0x4, 0x8 on consecutive cycles → each appears on outputs exactly one cycle later, back-to-back.
- **Decode stall (skid).** `out_ready_i=0` while pushing 0x10 then 0x14 → `in_ready_o=0` after the second transfer, and `inst_addr_o` stays 0x10. Raise `out_ready_i` → 0x10 then 0x14 are delivered, and `in_ready_o` returns to 1.
- **Flush.** Fill the stage to TWO (or ONE without skid) and assert `flush_i` together with `in_valid_i=1` at addr 0x20 → next cycle `out_valid_o=0` and `inst_o=NOP`. 0x20 never appears.
- **Fault tag.** Push 0x30 with `fault_i=1` → `fault_o=1` only while 0x30 is presented, and 0 otherwise.
- **Reset mid-stall.** Stage in TWO, assert `rst` → next cycle EMPTY, then normal acceptance resumes with no stale data.

Source files
------------

// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage: valid/ready handshake, flush, NOP when empty.
// Define IF_ID_SKID_EN for a two-entry skid buffer with a registered in_ready_o.
module if_id_pipe #(
  parameter int              DW       = 32,
  parameter int              AW       = 32,
  parameter logic [DW-1:0]   NOP_INST = DW'(32'h0000_0013)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] inst_i,
  input  logic [AW-1:0] inst_addr_i,
  input  logic          fault_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [DW-1:0] inst_o,
  output logic [AW-1:0] inst_addr_o,
  output logic          fault_o
);

  localparam int EW = DW + AW + 1;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [EW-1:0]   r_main_p1;
  logic            w_vld_p1;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_load_in;
  logic [EW-1:0]   w_in_ent;

`ifdef IF_ID_SKID_EN
  logic [EW-1:0]   r_skid_p1;
  logic            r_in_ready;
  logic            w_push_skid;
  logic            w_pop_skid;
`endif

  assign w_vld_p1   = (r_state != EMPTY);
  assign w_in_xfer  = in_valid_i && in_ready_o;
  assign w_out_xfer = w_vld_p1 && out_ready_i;
  assign w_in_ent   = {fault_i, inst_addr_i, inst_i};

  // Flush beats any handshake; an output transfer in the same cycle is still consumed.
  always_comb begin
    w_state_nxt = r_state;
    w_load_in   = 1'b0;
`ifdef IF_ID_SKID_EN
    w_push_skid = 1'b0;
    w_pop_skid  = 1'b0;
`endif
    if (flush_i) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ONE;
            w_load_in   = 1'b1;
          end
        end
        ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_load_in = 1'b1;
          end else if (w_out_xfer) begin
            w_state_nxt = EMPTY;
`ifdef IF_ID_SKID_EN
          end else if (w_in_xfer) begin
            w_state_nxt = TWO;
            w_push_skid = 1'b1;
`endif
          end
        end
`ifdef IF_ID_SKID_EN
        TWO: begin
          if (w_out_xfer) begin
            w_state_nxt = ONE;
            w_pop_skid  = 1'b1;
          end
        end
`endif
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Stage p1 storage: data is not reset, the occupancy state masks it.
  always_ff @(posedge clk) begin
    if (w_load_in) begin
      r_main_p1 <= w_in_ent;
`ifdef IF_ID_SKID_EN
    end else if (w_pop_skid) begin
      r_main_p1 <= r_skid_p1;
`endif
    end
  end

`ifdef IF_ID_SKID_EN
  always_ff @(posedge clk) begin
    if (w_push_skid) begin
      r_skid_p1 <= w_in_ent;
    end
  end

  // Registered ready decouples decode back-pressure from the fetch timing path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= (w_state_nxt != TWO);
    end
  end

  assign in_ready_o = r_in_ready;
`else
  assign in_ready_o = !w_vld_p1 || out_ready_i;
`endif

  assign out_valid_o = w_vld_p1;
  assign inst_o      = w_vld_p1 ? r_main_p1[DW-1:0]   : NOP_INST;
  assign inst_addr_o = w_vld_p1 ? r_main_p1[DW +: AW] : '0;
  assign fault_o     = w_vld_p1 ? r_main_p1[EW-1]     : 1'b0;

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: vector table, directed stall/reset sequences, random traffic vs a queue model.
module tb_if_id_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        fault_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        fault_o;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  if_id_pipe #(.DW(32), .AW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .fault_i     (fault_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .fault_o     (fault_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        fault;
  } ent_t;

  typedef struct {
    logic        r;
    logic        f;
    logic        iv;
    logic [31:0] a;
    logic        flt;
    logic        ordy;
    logic        chk;
    logic        ev;
    logic [31:0] ea;
    logic        ef;
    logic        erdy;
  } vec_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Stage accepts while it has room; the single-entry build may also reuse the slot being drained.
  function automatic logic m_ready();
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready_i;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic [31:0] inst,
                       input logic [31:0] a, input logic flt, input logic ordy);
    @(negedge clk);
    rst         = r;
    flush_i     = f;
    in_valid_i  = iv;
    inst_i      = inst;
    inst_addr_i = a;
    fault_i     = flt;
    out_ready_i = ordy;
    #1;
  endtask

  task automatic model_check(input string tag);
    if (q.size() > 0) begin
      check({tag, " valid"}, out_valid_o, 1'b1);
      check({tag, " inst"},  inst_o,      q[0].inst);
      check({tag, " addr"},  inst_addr_o, q[0].addr);
      check({tag, " fault"}, fault_o,     q[0].fault);
    end else begin
      check({tag, " valid"}, out_valid_o, 1'b0);
      check({tag, " inst"},  inst_o,      NOP);
      check({tag, " addr"},  inst_addr_o, 32'h0);
      check({tag, " fault"}, fault_o,     1'b0);
    end
    check({tag, " ready"}, in_ready_o, m_ready());
  endtask

  task automatic advance();
    logic ox, ix;
    ent_t e;
    ox = (q.size() > 0) && out_ready_i;
    ix = in_valid_i && m_ready();
    e.inst  = inst_i;
    e.addr  = inst_addr_i;
    e.fault = fault_i;
    @(posedge clk);
    if (rst || flush_i) begin
      q.delete();
    end else begin
      if (ox) void'(q.pop_front());
      if (ix) q.push_back(e);
    end
  endtask

  task automatic step(input string tag, input logic r, input logic f, input logic iv,
                      input logic [31:0] inst, input logic [31:0] a, input logic flt, input logic ordy);
    drive(r, f, iv, inst, a, flt, ordy);
    model_check(tag);
    advance();
  endtask

  vec_t tbl[14];

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; inst_i = '0; inst_addr_i = '0;
    fault_i = 1'b0; out_ready_i = 1'b1;

    //          r  f  iv  addr          flt ordy chk ev  exp addr      ef rdy
    tbl[0]  = '{1, 0, 1, 32'h0000_0100, 0, 1,   0,  0, 32'h0000_0000, 0, 1};
    tbl[1]  = '{1, 0, 1, 32'h0000_0104, 0, 1,   1,  0, 32'h0000_0000, 0, 1};
    tbl[2]  = '{0, 0, 1, 32'h0000_0000, 0, 1,   1,  0, 32'h0000_0000, 0, 1};
    tbl[3]  = '{0, 0, 1, 32'h0000_0004, 0, 1,   1,  1, 32'h0000_0000, 0, 1};
    tbl[4]  = '{0, 0, 1, 32'h0000_0008, 0, 1,   1,  1, 32'h0000_0004, 0, 1};
    tbl[5]  = '{0, 0, 0, 32'h0000_0000, 0, 1,   1,  1, 32'h0000_0008, 0, 1};
    tbl[6]  = '{0, 0, 1, 32'h0000_0030, 1, 1,   1,  0, 32'h0000_0000, 0, 1};
    tbl[7]  = '{0, 0, 1, 32'h0000_0034, 0, 1,   1,  1, 32'h0000_0030, 1, 1};
    tbl[8]  = '{0, 0, 0, 32'h0000_0000, 0, 1,   1,  1, 32'h0000_0034, 0, 1};
    tbl[9]  = '{0, 0, 0, 32'h0000_0000, 0, 1,   1,  0, 32'h0000_0000, 0, 1};
    tbl[10] = '{0, 0, 1, 32'h0000_0040, 0, 1,   1,  0, 32'h0000_0000, 0, 1};
    tbl[11] = '{0, 1, 1, 32'h0000_0020, 0, 1,   1,  1, 32'h0000_0040, 0, 1};
    tbl[12] = '{0, 0, 0, 32'h0000_0000, 0, 1,   1,  0, 32'h0000_0000, 0, 1};
    tbl[13] = '{0, 0, 0, 32'h0000_0000, 0, 1,   1,  0, 32'h0000_0000, 0, 1};

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].iv, inst_of(tbl[i].a), tbl[i].a, tbl[i].flt, tbl[i].ordy);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d valid", i), out_valid_o, tbl[i].ev);
        check($sformatf("vec%0d addr", i),  inst_addr_o, tbl[i].ea);
        check($sformatf("vec%0d inst", i),  inst_o, tbl[i].ev ? inst_of(tbl[i].ea) : NOP);
        check($sformatf("vec%0d fault", i), fault_o, tbl[i].ef);
        check($sformatf("vec%0d ready", i), in_ready_o, tbl[i].erdy);
      end
      advance();
    end

    // Decode stall while pushing 0x10 then 0x14.
    step("stall0", 0, 0, 1, inst_of(32'h10), 32'h10, 0, 0);
    step("stall1", 0, 0, 1, inst_of(32'h14), 32'h14, 0, 0);
    drive(0, 0, 0, 32'h0, 32'h0, 0, 0);
`ifdef IF_ID_SKID_EN
    check("stall full ready", in_ready_o, 1'b0);
`endif
    check("stall hold addr", inst_addr_o, 32'h10);
    model_check("stall2");
    advance();
    step("stall3", 0, 0, 0, 32'h0, 32'h0, 0, 1);
    step("stall4", 0, 0, 0, 32'h0, 32'h0, 0, 1);
    step("stall5", 0, 0, 0, 32'h0, 32'h0, 0, 1);

    // Reset while the stage is full.
    step("rstst0", 0, 0, 1, inst_of(32'h50), 32'h50, 0, 0);
    step("rstst1", 0, 0, 1, inst_of(32'h54), 32'h54, 0, 0);
    step("rstst2", 1, 0, 1, inst_of(32'h58), 32'h58, 0, 0);
    drive(0, 0, 1, inst_of(32'h60), 32'h60, 0, 1);
    check("rst_stall valid", out_valid_o, 1'b0);
    check("rst_stall ready", in_ready_o, 1'b1);
    model_check("rstst3");
    advance();
    drive(0, 0, 0, 32'h0, 32'h0, 0, 1);
    check("rst_stall resume addr", inst_addr_o, 32'h60);
    check("rst_stall resume valid", out_valid_o, 1'b1);
    model_check("rstst4");
    advance();

    // Random traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      step($sformatf("rnd%0d", n),
           ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom(),
           {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
